// File: rtl/ref_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : ref_row_fetch
//  Brief    : Fetches a REG_H x REG_W luma interpolation region from the
//             search-window SRAM (256 rows x 16 words x 16 pixels) and
//             streams it row by row to the interpolation filter. Rows below
//             row 255 replicate row 255; pixels right of word 15 replicate
//             the last pixel of the row.
//  Revision : 1.0  initial release
// ============================================================================
module ref_row_fetch #(
    parameter int REG_W = 9,   // pixels per output row, 1..16
    parameter int REG_H = 9    // rows per region, 1..256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [12:0]          addr_in,
    input  logic [3:0]           pos_in,
    output logic                 mem_rd_en,
    output logic [11:0]          mem_rd_addr,
    input  logic [127:0]         mem_rd_data,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [8*REG_W-1:0]   row_pix,
    output logic [7:0]           row_idx,
    output logic                 row_last
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic [4:0] c_last_k = 5'(REG_W - 1);
    localparam logic [7:0] c_last_r = 8'(REG_H - 1);

    logic [2:0]           state_q,   state_d;
    logic [7:0]           row_q,     row_d;
    logic [3:0]           col_q,     col_d;
    logic [3:0]           pos_q,     pos_d;
    logic [7:0]           r_q,       r_d;
    logic [127:0]         w0_q,      w0_d;
    logic                 sec_q,     sec_d;
    logic [8*REG_W-1:0]   row_pix_q, row_pix_d;

    logic [8:0]           w_sum;
    logic [7:0]           w_rowc;
    logic [3:0]           w_col_nxt;
    logic                 w_need2;
    logic                 w_col_edge;
    logic                 w_second_rd;
    logic                 w_last_row;
    logic [127:0]         w_w1;
    logic [8*REG_W-1:0]   w_pix_asm;

    // Bit 12 of the request address is architecturally zero and carries no information.
    logic                 w_unused;
    assign w_unused = addr_in[12];

    // Row address with bottom clamp, next word column (only formed when a right neighbour exists).
    always_comb begin
        w_sum       = {1'b0, row_q} + {1'b0, r_q};
        w_rowc      = w_sum[8] ? 8'hFF : w_sum[7:0];
        w_col_edge  = (col_q == 4'hF);
        w_col_nxt   = w_col_edge ? col_q : col_q + 4'd1;
        w_need2     = ({1'b0, pos_q} < c_last_k);
        w_second_rd = w_need2 && !w_col_edge;
        w_last_row  = (r_q == c_last_r);
    end

    // Row assembly: pixels walk down from byte pos of w0, then continue from byte 15 of w1.
    always_comb begin
        w_w1      = sec_q ? mem_rd_data : {16{w0_q[7:0]}};
        w_pix_asm = '0;
        for (int k = 0; k < REG_W; k++) begin
            if (5'(k) <= {1'b0, pos_q}) begin
                w_pix_asm[8*k +: 8] = w0_q[{pos_q - 4'(k), 3'b000} +: 8];
            end else begin
                w_pix_asm[8*k +: 8] = w_w1[{pos_q - 4'(k), 3'b000} +: 8];
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            pos_q     <= '0;
            r_q       <= '0;
            w0_q      <= '0;
            sec_q     <= 1'b0;
            row_pix_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pos_q     <= pos_d;
            r_q       <= r_d;
            w0_q      <= w0_d;
            sec_q     <= sec_d;
            row_pix_q <= row_pix_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_CAP;
            S_CAP:   state_d = S_OUT;
            S_OUT:   if (row_ready) state_d = w_last_row ? S_IDLE : S_RD0;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates: latch request, capture words, build the row, advance row counter.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        pos_d     = pos_q;
        r_d       = r_q;
        w0_d      = w0_q;
        sec_d     = sec_q;
        row_pix_d = row_pix_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    row_d = addr_in[11:4];
                    col_d = addr_in[3:0];
                    pos_d = pos_in;
                    r_d   = 8'd0;
                end
            end
            S_RD1: begin
                w0_d  = mem_rd_data;
                sec_d = w_second_rd;
            end
            S_CAP: begin
                row_pix_d = w_pix_asm;
            end
            S_OUT: begin
                if (row_ready && !w_last_row) begin
                    r_d = r_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        mem_rd_en   = 1'b0;
        mem_rd_addr = 12'd0;
        if (state_q == S_RD0) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = {w_rowc, col_q};
        end else if (state_q == S_RD1 && w_second_rd) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = {w_rowc, w_col_nxt};
        end
        row_valid = (state_q == S_OUT);
        row_pix   = row_pix_q;
        row_idx   = r_q;
        row_last  = (state_q == S_OUT) && w_last_row;
    end

endmodule
`default_nettype wire

// File: tb/tb_ref_row_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ref_row_fetch
//  Brief    : Self-checking bench for ref_row_fetch. Region contents are
//             predicted from a 256-pixel-per-line picture model with bottom
//             and right clamping; SRAM is a behavioural array.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ref_row_fetch;

    localparam int REG_W = 9;
    localparam int REG_H = 9;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [12:0]          addr_in;
    logic [3:0]           pos_in;
    logic                 mem_rd_en;
    logic [11:0]          mem_rd_addr;
    logic [127:0]         mem_rd_data;
    logic                 row_valid;
    logic                 row_ready;
    logic [8*REG_W-1:0]   row_pix;
    logic [7:0]           row_idx;
    logic                 row_last;

    ref_row_fetch #(.REG_W(REG_W), .REG_H(REG_H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .addr_in     (addr_in),
        .pos_in      (pos_in),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_pix     (row_pix),
        .row_idx     (row_idx),
        .row_last    (row_last)
    );

    always #5 clk = ~clk;

    // SRAM: one-cycle read latency; garbage on the bus when not reading.
    logic [127:0] mem [4096];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        else           mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Log of every read address issued.
    logic [11:0] rd_q[$];
    always @(posedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_rd_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Picture model: each SRAM row is a 256-pixel line, pixel L at word L/16, byte 15-L%16.
    function automatic int mrow(input logic [12:0] a, input int r);
        int row;
        row = int'(a[11:4]) + r;
        if (row > 255) row = 255;
        return row;
    endfunction

    function automatic logic [127:0] ref_row(input logic [12:0] a, input logic [3:0] p, input int r);
        logic [127:0] v;
        int row;
        int lp;
        v   = '0;
        row = mrow(a, r);
        for (int k = 0; k < REG_W; k++) begin
            lp = int'(a[3:0]) * 16 + 15 - int'(p) + k;
            if (lp > 255) lp = 255;
            v[8*k +: 8] = mem[row*16 + lp/16][8*(15 - lp%16) +: 8];
        end
        return v;
    endfunction

    // Number of SRAM words the row spans inside the window (1 or 2).
    function automatic int ref_nrd(input logic [12:0] a, input logic [3:0] p);
        int lend;
        lend = int'(a[3:0]) * 16 + 15 - int'(p) + REG_W - 1;
        if ((lend / 16) != int'(a[3:0]) && a[3:0] != 4'hF) return 2;
        return 1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),    128'(1));
        chk({tag, "_rd_en"},     128'(mem_rd_en),   128'(0));
        chk({tag, "_rd_addr"},   128'(mem_rd_addr), 128'(0));
        chk({tag, "_row_valid"}, 128'(row_valid),   128'(0));
        chk({tag, "_row_pix"},   128'(row_pix),     128'(0));
        chk({tag, "_row_idx"},   128'(row_idx),     128'(0));
        chk({tag, "_row_last"},  128'(row_last),    128'(0));
    endtask

    // One full region request; optional stall on one row, reset on one row, junk requests while busy.
    task automatic run_region(input logic [12:0] a, input logic [3:0] p, input int exp_nrd,
                              input logic [11:0] exp_last, input int stall_row, input int stall_n,
                              input int rst_row, input bit junk);
        int           cyc;
        logic [127:0] held;
        logic [11:0]  base;
        @(negedge clk);
        chk("idle_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        addr_in  = a;
        pos_in   = p;
        rd_q.delete();
        @(posedge clk);
        #1;
        if (junk) begin
            addr_in = {1'b0, 12'($urandom)};
            pos_in  = 4'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        for (int r = 0; r < REG_H; r++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) chk($sformatf("rd0_strobe_r%0d", r), 128'(mem_rd_en), 128'(1));
            end while (!row_valid && cyc < 20);
            chk($sformatf("row_latency_r%0d", r), 128'(cyc), 128'(4));
            chk($sformatf("row_idx_r%0d", r), 128'(row_idx), 128'(r));
            chk($sformatf("row_last_r%0d", r), 128'(row_last), 128'(r == REG_H - 1));
            chk($sformatf("row_pix_a%h_p%0d_r%0d", a, p, r), 128'(row_pix), ref_row(a, p, r));
            chk($sformatf("rd_count_r%0d", r), 128'(rd_q.size()), 128'(exp_nrd));
            base = {8'(mrow(a, r)), a[3:0]};
            if (rd_q.size() >= 1) chk($sformatf("rd_addr0_r%0d", r), 128'(rd_q[0]), 128'(base));
            if (rd_q.size() >= 2) chk($sformatf("rd_addr1_r%0d", r), 128'(rd_q[1]), 128'(base + 12'd1));
            if (r == REG_H - 1 && rd_q.size() >= 1) chk("rd_last_row", 128'(rd_q[0]), 128'(exp_last));
            rd_q.delete();
            if (r == rst_row) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs("async_rst");
                in_valid = 1'b0;
                repeat (2) @(negedge clk);
                chk_reset_outputs("held_rst");
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_ready", 128'(in_ready), 128'(1));
                chk("post_rst_no_reads", 128'(rd_q.size()), 128'(0));
                return;
            end
            if (r == stall_row) begin
                row_ready = 1'b0;
                held      = 128'(row_pix);
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_valid", 128'(row_valid), 128'(1));
                    chk("stall_pix",   128'(row_pix),   held);
                    chk("stall_idx",   128'(row_idx),   128'(r));
                    chk("stall_no_rd", 128'(mem_rd_en), 128'(0));
                end
                row_ready = 1'b1;
            end
            if (r == REG_H - 1) in_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        chk("done_in_ready",  128'(in_ready),  128'(1));
        chk("done_row_valid", 128'(row_valid), 128'(0));
        chk("done_no_rd",     128'(mem_rd_en), 128'(0));
    endtask

    typedef struct {
        logic [12:0] addr;
        logic [3:0]  pos;
        int          nrd;       // expected reads per row
        logic [11:0] last_rd;   // expected word address of the final row
        int          stall_row;
        int          stall_n;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{13'h123, 4'd15, 1, 12'h1A3, -1, 0};   // aligned
        tbl[1] = '{13'h045, 4'd3,  2, 12'h0C5,  2, 5};   // crossing + backpressure on row 2
        tbl[2] = '{13'h02F, 4'd1,  1, 12'h0AF, -1, 0};   // right-edge pad
        tbl[3] = '{13'hFA0, 4'd15, 1, 12'hFF0, -1, 0};   // bottom clamp
        tbl[4] = '{13'h7F8, 4'd8,  1, 12'h878, -1, 0};   // just fits in one word
        tbl[5] = '{13'h7F7, 4'd7,  2, 12'h877, -1, 0};   // just spills into next word
        tbl[6] = '{13'hFFE, 4'd0,  2, 12'hFFE,  0, 2};   // bottom clamp + crossing, stall row 0

        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        addr_in   = '0;
        pos_in    = '0;
        row_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_region(tbl[i].addr, tbl[i].pos, tbl[i].nrd, tbl[i].last_rd,
                       tbl[i].stall_row, tbl[i].stall_n, -1, 1'b0);
        end

        // Reset during row 4, then a fresh region must start from row 0.
        run_region(13'h333, 4'd5, 2, 12'h3B3, -1, 0, 4, 1'b1);
        run_region(13'h011, 4'd9, 1, 12'h091, -1, 0, -1, 1'b0);

        // Randomised regions checked against the picture model.
        for (int i = 0; i < 10; i++) begin
            logic [12:0] a;
            logic [3:0]  p;
            a = {1'b0, 12'($urandom)};
            p = 4'($urandom);
            run_region(a, p, ref_nrd(a, p), {8'(mrow(a, REG_H - 1)), a[3:0]},
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, REG_H - 1)) : -1,
                       int'($urandom_range(1, 4)), -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
